// File: rtl/aspen_pkg.sv
// Shared definitions for the signed PIF neuron datapath and its weight feeder.
package aspen_pkg;

  localparam int DATA_WIDTH_FRAC_DEF = 8;
  localparam int NUM_INPUT_DEF       = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pif_weight_streamer_if.sv
// Bundle of the streamer's control, weight-memory and neuron-side signals.
interface pif_weight_streamer_if
  import aspen_pkg::*;
#(
  parameter int DATA_WIDTH_FRAC = DATA_WIDTH_FRAC_DEF,
  parameter int NUM_INPUT       = NUM_INPUT_DEF,
  parameter int SIZE_CODE       = $clog2(NUM_INPUT)
) ();

  logic                              start;
  logic        [NUM_INPUT-1:0]       spikeIn;
  logic                              memEn;
  logic        [SIZE_CODE-1:0]       memAddr;
  logic signed [DATA_WIDTH_FRAC-1:0] memData;
  logic                              readyMem;
  logic signed [DATA_WIDTH_FRAC-1:0] weightData;
  logic                              enable;
  logic                              finished;
  logic                              busy;
  logic        [SIZE_CODE:0]         weightCount;

  // A weight transfers in every cycle where readyMem is high and the streamer
  // holds a buffered weight; weightData is that weight, and zero in all other
  // cycles. memData is sampled exactly one cycle after memEn.
  modport slave (
    input  start, spikeIn, memData, readyMem,
    output memEn, memAddr, weightData, enable, finished, busy, weightCount
  );

  modport master (
    output start, spikeIn, memData, readyMem,
    input  memEn, memAddr, weightData, enable, finished, busy, weightCount
  );

endinterface

// File: rtl/weight_skid_fifo.sv
// Two-entry signed FIFO buffering weight-memory returns ahead of the neuron.
module weight_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic signed [WIDTH-1:0] data_i,
  input  logic                    pop_i,
  output logic signed [WIDTH-1:0] head_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [1:0]              count_o
);

  logic signed [WIDTH-1:0] mem_q [2];
  logic                    wr_q;
  logic                    rd_q;
  logic [1:0]              count_q;
  logic                    push_ok;
  logic                    pop_ok;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/pif_weight_streamer.sv
// Scans a latched spike vector, fetches each spiking synapse's weight and streams it to the neuron.
module pif_weight_streamer
  import aspen_pkg::*;
#(
  parameter int DATA_WIDTH_FRAC = DATA_WIDTH_FRAC_DEF,
  parameter int NUM_INPUT       = NUM_INPUT_DEF,
  parameter int SIZE_CODE       = $clog2(NUM_INPUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  pif_weight_streamer_if.slave bus,
  output state_t               dbg_state_o
);

  localparam logic [SIZE_CODE-1:0] LAST_IDX = SIZE_CODE'(NUM_INPUT - 1);

  state_t                      state_q, state_d;
  logic [NUM_INPUT-1:0]        spike_q, spike_d;
  logic [SIZE_CODE-1:0]        ptr_q, ptr_d;
  logic [SIZE_CODE:0]          cnt_q, cnt_d;
  logic                        enable_q, enable_d;
  logic                        finished_q, finished_d;
  logic                        inflight_q, inflight_d;

  logic signed [DATA_WIDTH_FRAC-1:0] fifo_head;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic [1:0]                  fifo_count;
  logic                        pop;
  logic                        issue;
  logic                        credit_ok;
  logic                        drained;
  logic [2:0]                  occ;

  weight_skid_fifo #(.WIDTH(DATA_WIDTH_FRAC)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (inflight_q),
    .data_i  (bus.memData),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign pop = bus.readyMem && !fifo_empty;

  // Slots committed next cycle: buffered plus in-flight, minus the one leaving now.
  assign occ       = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign credit_ok = (occ < 3'd2);
  assign drained   = !inflight_q && (fifo_empty || (pop && !fifo_full));

  always_comb begin
    state_d    = state_q;
    spike_d    = spike_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q + {{SIZE_CODE{1'b0}}, pop};
    enable_d   = enable_q;
    finished_d = finished_q;
    issue      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          spike_d    = bus.spikeIn;
          ptr_d      = '0;
          cnt_d      = '0;
          enable_d   = 1'b1;
          finished_d = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        issue = spike_q[ptr_q] && credit_ok;
        if (!spike_q[ptr_q] || credit_ok) begin
          if (ptr_q == LAST_IDX) begin
            // With nothing outstanding the timestep can close straight from the last index.
            if (!issue && drained) begin
              state_d    = DONE;
              finished_d = 1'b1;
              enable_d   = 1'b0;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          state_d    = DONE;
          finished_d = 1'b1;
          enable_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inflight_d = issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      spike_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      enable_q   <= 1'b0;
      finished_q <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      spike_q    <= spike_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      enable_q   <= enable_d;
      finished_q <= finished_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.memEn       = issue;
  assign bus.memAddr     = issue ? ptr_q : '0;
  assign bus.weightData  = pop ? fifo_head : '0;
  assign bus.enable      = enable_q;
  assign bus.finished    = finished_q;
  assign bus.busy        = (state_q == SCAN) || (state_q == DRAIN);
  assign bus.weightCount = cnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_pif_weight_streamer.sv
// Bench for pif_weight_streamer: weight-memory model, delivery scoreboard and timestep vectors.
module tb_pif_weight_streamer;
  import aspen_pkg::*;

  localparam int DW = 8;
  localparam int NI = 31;
  localparam int SC = $clog2(NI);

  typedef struct {
    logic [NI-1:0] spikes;
    int            wsel;      // 0: weight i = i-15, 1: random, 2: 0x40/0x80/0x7F at 0/7/30
    int            rmode;     // 0: ready high, 1: 1,0,0,1 pattern, 2: random
    int            pulse_at;  // cycle of an extra start pulse, 0 = none
    int            exp_first; // expected first/last delivery cycle, 0 = not checked
    int            exp_last;
    int            exp_done;  // expected cycle finished is first seen, 0 = not checked
  } vec_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;
  int     cyc = 0;
  int     t0  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pif_weight_streamer_if #(.DATA_WIDTH_FRAC(DW), .NUM_INPUT(NI), .SIZE_CODE(SC)) bus ();

  pif_weight_streamer #(.DATA_WIDTH_FRAC(DW), .NUM_INPUT(NI), .SIZE_CODE(SC)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- weight memory model ----------------
  logic [DW-1:0] weight_mem [NI];

  always @(posedge clk)
    bus.memData <= bus.memEn ? weight_mem[bus.memAddr] : DW'($urandom);

  // ---------------- readyMem driver ----------------
  int ready_mode = 3;
  int phase      = 0;

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.readyMem = 1'b1;
      1:       bus.readyMem = ((phase % 4) == 0) || ((phase % 4) == 3);
      2:       bus.readyMem = 1'($urandom_range(0, 1));
      default: bus.readyMem = 1'b0;
    endcase
    phase++;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] prev_wd   = '0;
  logic [SC:0]   prev_cnt  = '0;
  int            prev_rel  = 0;
  int            first_del = -1;
  int            last_del  = -1;
  int            last_addr = -1;
  logic [NI-1:0] spike_vec = '0;

  // A delivery in cycle k shows up as weightCount stepping by one at cycle k+1.
  always @(negedge clk) begin
    if (bus.weightCount == (SC + 1)'(prev_cnt + 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery: got %0h expected none", prev_wd);
      end else begin
        chk("weight", prev_wd, exp_q.pop_front());
      end
      if (first_del < 0) first_del = prev_rel;
      last_del = prev_rel;
    end else begin
      chk("idle_weightData", prev_wd, 0);
    end
    if (bus.memEn) begin
      chk("memAddr_spike", spike_vec[bus.memAddr], 1);
      chk("memAddr_order", int'(bus.memAddr) > last_addr, 1);
      last_addr = int'(bus.memAddr);
    end
    prev_wd  = bus.weightData;
    prev_cnt = bus.weightCount;
    prev_rel = cyc - t0 + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_memEn"},       bus.memEn, 0);
    chk({pfx, "_memAddr"},     bus.memAddr, 0);
    chk({pfx, "_weightData"},  bus.weightData, 0);
    chk({pfx, "_enable"},      bus.enable, 0);
    chk({pfx, "_finished"},    bus.finished, 0);
    chk({pfx, "_busy"},        bus.busy, 0);
    chk({pfx, "_weightCount"}, bus.weightCount, 0);
    chk({pfx, "_state"},       dbg_state, IDLE);
  endtask

  task automatic run_vec(input vec_t v);
    int done_cyc;
    for (int i = 0; i < NI; i++) begin
      case (v.wsel)
        0:       weight_mem[i] = DW'(i - 15);
        1:       weight_mem[i] = DW'($urandom);
        default: weight_mem[i] = '0;
      endcase
    end
    if (v.wsel == 2) begin
      weight_mem[0]  = 8'h40;
      weight_mem[7]  = 8'h80;
      weight_mem[30] = 8'h7F;
    end
    @(negedge clk);
    ready_mode = v.rmode;
    phase      = 0;
    spike_vec  = v.spikes;
    last_addr  = -1;
    first_del  = -1;
    last_del   = -1;
    for (int i = 0; i < NI; i++)
      if (v.spikes[i]) exp_q.push_back(weight_mem[i]);
    bus.start   = 1'b1;
    bus.spikeIn = v.spikes;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.spikeIn = NI'($urandom);
    t0          = cyc;
    done_cyc    = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("enable_c1",   bus.enable, 1);
        chk("busy_c1",     bus.busy, 1);
        chk("finished_c1", bus.finished, 0);
      end
      if (bus.finished) begin
        done_cyc = k;
        break;
      end
      if (k == v.pulse_at) begin
        bus.start   = 1'b1;
        bus.spikeIn = '0;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_in_budget", done_cyc > 0, 1);
    chk("weightCount",    bus.weightCount, $countones(v.spikes));
    chk("enable_done",    bus.enable, 0);
    chk("busy_done",      bus.busy, 0);
    chk("finished_held",  bus.finished, 1);
    chk("queue_drained",  exp_q.size(), 0);
    if (v.exp_done > 0) chk("done_cycle", done_cyc, v.exp_done);
    if (v.exp_first > 0) begin
      chk("first_cycle", first_del, v.exp_first);
      chk("last_cycle",  last_del,  v.exp_last);
    end
    exp_q.delete();
  endtask

  // Abort two cycles into a timestep, while a memory return is still in flight.
  task automatic reset_mid_scan();
    @(negedge clk);
    ready_mode = 3;
    spike_vec  = '1;
    last_addr  = -1;
    for (int i = 0; i < NI; i++) weight_mem[i] = DW'(i - 15);
    bus.start   = 1'b1;
    bus.spikeIn = '1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t0        = cyc;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[9];

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.spikeIn = '0;
    bus.readyMem = 1'b0;

    vecs[0] = '{spikes: '1,                  wsel: 0, rmode: 0, pulse_at: 0, exp_first: 3, exp_last: 33, exp_done: 0};
    vecs[1] = '{spikes: '0,                  wsel: 0, rmode: 0, pulse_at: 0, exp_first: 0, exp_last: 0,  exp_done: 32};
    vecs[2] = '{spikes: NI'(32'h4000_0081),  wsel: 2, rmode: 0, pulse_at: 0, exp_first: 3, exp_last: 33, exp_done: 0};
    vecs[3] = '{spikes: '1,                  wsel: 1, rmode: 1, pulse_at: 0, exp_first: 0, exp_last: 0,  exp_done: 0};
    vecs[4] = '{spikes: NI'($urandom),       wsel: 1, rmode: 2, pulse_at: 0, exp_first: 0, exp_last: 0,  exp_done: 0};
    vecs[5] = '{spikes: '1,                  wsel: 0, rmode: 0, pulse_at: 5, exp_first: 3, exp_last: 33, exp_done: 0};
    vecs[6] = '{spikes: NI'($urandom),       wsel: 1, rmode: 0, pulse_at: 0, exp_first: 0, exp_last: 0,  exp_done: 0};
    vecs[7] = '{spikes: '0,                  wsel: 1, rmode: 0, pulse_at: 0, exp_first: 0, exp_last: 0,  exp_done: 32};
    vecs[8] = '{spikes: '1,                  wsel: 1, rmode: 0, pulse_at: 0, exp_first: 3, exp_last: 33, exp_done: 0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    reset_mid_scan();
    for (int i = 7; i < 9; i++) run_vec(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
